store_write_buffer: RTL

Buffers store requests from the core's memory stage and drives them onto a generic write interface as its B-side (master) driver. A small FIFO decouples the core from slow write targets. A response-timeout watchdog keeps a dead slave from hanging the pipeline.

---
 rtl/store_write_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: queues core stores in a small FIFO and issues them one at a
// time on a valid/response write interface, dropping entries whose slave never answers.
module store_write_buffer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     store_valid,
  output logic                     store_ready,
  input  logic [$clog2(DEPTH)-1:0] store_address,
  input  logic [WIDTH-1:0]         store_data,
  input  logic [1:0]               store_size,
  output logic                     write_clock,
  output logic [$clog2(DEPTH)-1:0] write_address,
  output logic                     write_valid,
  output logic [WIDTH-1:0]         write_data,
  output logic [$clog2(WIDTH)-1:0] write_size,
  input  logic                     write_response,
  output logic                     busy,
  output logic                     illegal_size,
  output logic                     timeout_error,
  input  logic                     clear_errors
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SZ_W   = $clog2(WIDTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic [SZ_W-1:0]   size;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  timer;
  state_t            state;
  entry_t            head, head_nxt, in_entry;
  logic              size_legal, push, enq, timed_out, pop;

  assign write_clock = clock;
  assign store_ready = (count != CNT_W'(FIFO_DEPTH));
  assign busy        = (count != '0) || write_valid;

  assign size_legal = (store_size != 2'd3) && ((32'd8 << store_size) <= 32'(WIDTH));
  assign push       = store_valid && store_ready;
  assign enq        = push && size_legal;
  assign in_entry   = '{addr: store_address, data: store_data,
                        size: SZ_W'((32'd8 << store_size) - 32'd1)};

  // Timer holds cycles already spent in WAIT, so the drop lands TIMEOUT edges after the load.
  assign timed_out = (state == S_WAIT) && !write_response && (timer == TMR_W'(TIMEOUT - 1));
  assign pop       = (state == S_WAIT) && (write_response || timed_out);

  assign rd_nxt   = rd_ptr + 1'b1;
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_nxt];

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      timer         <= '0;
      write_valid   <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      write_size    <= '0;
      illegal_size  <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(pop);

      if (push && !size_legal) illegal_size <= 1'b1;
      else if (clear_errors)   illegal_size <= 1'b0;
      if (timed_out)           timeout_error <= 1'b1;
      else if (clear_errors)   timeout_error <= 1'b0;

      case (state)
        S_IDLE: begin
          if (count != '0) begin
            write_address <= head.addr;
            write_data    <= head.data;
            write_size    <= head.size;
            write_valid   <= 1'b1;
            timer         <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pop) begin
            rd_ptr <= rd_nxt;
            // Head stays queued while in flight, so a second entry means count > 1.
            if (count > CNT_W'(1)) begin
              write_address <= head_nxt.addr;
              write_data    <= head_nxt.data;
              write_size    <= head_nxt.size;
              timer         <= '0;
            end else begin
              write_valid <= 1'b0;
              state       <= S_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
